fp_mul_param: RTL and testbench
===============================

Name: fp_mul_param

Overview:
- Parametrised IEEE-754-style floating-point multiplier. Next generation of the single-precision `mul` unit used by the Newton-Raphson datapath.
- Configurable exponent and fraction widths, so one block serves single, half and custom formats.
- Adds a full valid/ack handshake on both sides, selectable rounding mode, special-value handling and exception flags.
- Multi-cycle FSM; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width (>=3)
- MAN_W, 23, stored fraction width (>=2); word width W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- input_a  in  W  operand A, sampled on accept edge
- input_b  in  W  operand B, sampled on accept edge
- round_mode  in  1  0 = round-to-nearest-even, 1 = truncate toward zero; sampled on accept edge
- input_stb  in  1  operands valid
- input_ack  out  1  block ready; accept edge = rising edge with input_stb && input_ack
- output_z  out  W  result
- output_flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact
- output_z_stb  out  1  result valid
- output_z_ack  in  1  consumer takes result

Behaviour:
- Reset values (async): state=IDLE, input_ack=0, output_z=0, output_z_stb=0, output_flags=0.
- input_ack rises on the first edge after rst deasserts.
- Reset mid-operation aborts the op, returns to IDLE and drops output_z_stb immediately.
- FSM: IDLE -> UNPACK -> SPECIAL -> MULT -> NORM -> ROUND -> OUT -> IDLE.
  - input_ack = 1 only in IDLE.
  - Accept edge E enters UNPACK and clears input_ack.
  - Each following edge advances one state; OUT is entered at E+5.
  - output_z_stb = 1 in OUT. output_z and output_flags are stable throughout OUT.
  - Edge with output_z_ack=1 in OUT -> IDLE: output_z_stb=0, input_ack=1. output_z holds its value.
  - output_z_ack outside OUT is ignored. input_stb outside IDLE is ignored (no accept).
- Latency: fixed 5 cycles for all operand classes, including specials.
- Minimum accept-to-accept spacing: 7 cycles with output_z_ack tied high.
- UNPACK: split sign, exponent, fraction. Exponent 0 (zero or denormal) is treated as zero: inputs are flushed to zero with no flag.
- SPECIAL: result sign = sa ^ sb. Priority order:
  1. Either NaN -> canonical qNaN: sign 0, exp all ones, fraction MSB 1, rest 0. No flag.
  2. inf x zero -> canonical qNaN, invalid=1.
  3. inf x finite -> signed inf.
  4. zero x finite -> signed zero.
  - Special results pass through the remaining states unchanged.
- MULT: significands {1,frac} multiplied into a 2*(MAN_W+1)-bit product. Exponent e = ea + eb - BIAS, computed signed with EXP_W+2 bits, BIAS = 2^(EXP_W-1)-1.
- NORM: if product MSB set, take the upper bits and e+=1. Otherwise shift left one. Retain guard bit and sticky (OR of the remaining low bits).
- ROUND:
  - RNE increments when guard && (sticky || lsb). Truncate never increments.
  - inexact = guard || sticky.
  - Mantissa carry-out renormalises: fraction = 0, e += 1.
- Post-round classification:
  - e >= 2^EXP_W-1: overflow=1, inexact=1. RNE gives signed inf; truncate gives signed max finite (exp all ones minus 1, fraction all ones).
  - e <= 0: flushed to signed zero, underflow=1, inexact=1.
- Flags are valid only with output_z_stb; they are reset to 0 on each accept.

Test Plan (defaults, W=32, round_mode=0 unless stated):
- Basic products: 0x40800000 x 0x40A00000 -> 0x41A00000; 0xC0A00000 x 0x40000000 -> 0xC1200000; 0x40E00000 x 0xC1100000 -> 0xC27C0000. Flags 0, output_z_stb exactly 5 cycles after accept.
- Rounding mode: 0x3FC00000 x 0x3F800001 -> 0x3FC00002 with mode 0, 0x3FC00001 with mode 1; inexact=1 in both.
- Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1. 0xFF800000 x 0x40000000 -> 0xFF800000. 0x7FC00001 x 0x3F800000 -> 0x7FC00000, flags 0.
- Range: 0x7F000000 x 0x7F000000 -> 0x7F800000 (mode 0) / 0x7F7FFFFF (mode 1), overflow=1 and inexact=1. 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1. Denormal 0x00000001 x 0x40000000 -> 0x00000000, flags 0.
- Handshake: hold output_z_ack=0 for 10 cycles -> output_z_stb, output_z and flags held, input_ack=0, new input_stb ignored. Assert rst in MULT -> output_z_stb=0 and IDLE immediately; the next op 4x5 still gives 0x41A00000.
- Re-parametrised half format (EXP_W=5, MAN_W=10): 0x4400 x 0x4500 -> 0x4D00. 0x7800 x 0x7800 -> 0x7C00 with overflow=1.

Source files
------------

// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754-style multiplier with valid/ack handshakes, RNE/truncate rounding and exception flags.
// One operation in flight; a fixed five-state pipeline walk from accept to result, specials included.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   round_mode,
  input  logic                   input_stb,
  output logic                   input_ack,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic [3:0]             output_flags,
  output logic                   output_z_stb,
  input  logic                   output_z_ack
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int P = 2 * (MAN_W + 1);
  localparam logic signed [EXP_W+1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EXP_W+1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_MULT, S_NORM, S_ROUND, S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]             a_q, b_q, z_q, spec_z_q;
  logic                     rm_q, sz_q, spec_q, spec_inv_q;
  logic [EXP_W-1:0]         ea_q, eb_q;
  logic [MAN_W-1:0]         fa_q, fb_q, frac_q;
  logic [P-1:0]             prod_q;
  logic signed [EXP_W+1:0]  e_q;
  logic                     guard_q, sticky_q;
  logic [3:0]               flags_q;
  logic                     stb_q, ack_q;

  wire accept = (state_q == S_IDLE) && input_stb && ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_UNPACK;
      S_UNPACK:  state_d = S_SPECIAL;
      S_SPECIAL: state_d = S_MULT;
      S_MULT:    state_d = S_NORM;
      S_NORM:    state_d = S_ROUND;
      S_ROUND:   state_d = S_OUT;
      S_OUT:     if (output_z_ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand classification; exponent 0 covers both zero and flushed denormals.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  always_comb begin
    a_zero = (ea_q == '0);
    b_zero = (eb_q == '0);
    a_inf  = (ea_q == '1) && (fa_q == '0);
    b_inf  = (eb_q == '1) && (fb_q == '0);
    a_nan  = (ea_q == '1) && (fa_q != '0);
    b_nan  = (eb_q == '1) && (fb_q != '0);
  end

  // Normalisation selects the window one bit lower when the product is below 2.0.
  logic [MAN_W-1:0]        frac_n;
  logic                    guard_n, sticky_n;
  logic signed [EXP_W+1:0] e_n;
  always_comb begin
    if (prod_q[P-1]) begin
      frac_n   = prod_q[P-2 -: MAN_W];
      guard_n  = prod_q[MAN_W];
      sticky_n = |prod_q[MAN_W-1:0];
      e_n      = e_q + 1'sd1;
    end else begin
      frac_n   = prod_q[P-3 -: MAN_W];
      guard_n  = prod_q[MAN_W-1];
      sticky_n = |prod_q[MAN_W-2:0];
      e_n      = e_q;
    end
  end

  logic                    inc, carry, inexact;
  logic [MAN_W-1:0]        frac_r;
  logic signed [EXP_W+1:0] e_r;
  logic [W-1:0]            z_r;
  logic [3:0]              flags_r;
  always_comb begin
    inc             = ~rm_q & guard_q & (sticky_q | frac_q[0]);
    {carry, frac_r} = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc};
    e_r             = carry ? e_q + 1'sd1 : e_q;
    inexact         = guard_q | sticky_q;
    z_r             = {sz_q, e_r[EXP_W-1:0], frac_r};
    flags_r         = {3'b000, inexact};
    if (spec_q) begin
      z_r     = spec_z_q;
      flags_r = {spec_inv_q, 3'b000};
    end else if (e_r >= EMAX) begin
      z_r     = rm_q ? {sz_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                     : {sz_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_r = 4'b0101;
    end else if (e_r <= 0) begin
      z_r     = {sz_q, {(W-1){1'b0}}};
      flags_r = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; rm_q <= 1'b0;
      sz_q <= 1'b0; ea_q <= '0; eb_q <= '0; fa_q <= '0; fb_q <= '0;
      spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_z_q <= '0;
      prod_q <= '0; e_q <= '0; frac_q <= '0; guard_q <= 1'b0; sticky_q <= 1'b0;
      z_q <= '0; flags_q <= '0; stb_q <= 1'b0; ack_q <= 1'b0;
    end else begin
      ack_q <= (state_d == S_IDLE);
      stb_q <= (state_d == S_OUT);
      case (state_q)
        S_IDLE: if (accept) begin
          a_q <= input_a; b_q <= input_b; rm_q <= round_mode;
          flags_q <= '0;
        end
        S_UNPACK: begin
          sz_q <= a_q[W-1] ^ b_q[W-1];
          ea_q <= a_q[W-2 -: EXP_W];
          eb_q <= b_q[W-2 -: EXP_W];
          fa_q <= a_q[MAN_W-1:0];
          fb_q <= b_q[MAN_W-1:0];
        end
        S_SPECIAL: begin
          spec_q     <= a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
          spec_inv_q <= 1'b0;
          if (a_nan || b_nan) spec_z_q <= QNAN;
          else if ((a_inf || b_inf) && (a_zero || b_zero)) begin
            spec_z_q   <= QNAN;
            spec_inv_q <= 1'b1;
          end else if (a_inf || b_inf) spec_z_q <= {sz_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else spec_z_q <= {sz_q, {(W-1){1'b0}}};
        end
        S_MULT: begin
          prod_q <= {{(MAN_W+1){1'b0}}, 1'b1, fa_q} * {{(MAN_W+1){1'b0}}, 1'b1, fb_q};
          e_q    <= $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS;
        end
        S_NORM: begin
          frac_q <= frac_n; guard_q <= guard_n; sticky_q <= sticky_n; e_q <= e_n;
        end
        S_ROUND: begin
          z_q <= z_r; flags_q <= flags_r;
        end
        default: ;
      endcase
    end
  end

  assign input_ack    = ack_q;
  assign output_z     = z_q;
  assign output_flags = flags_q;
  assign output_z_stb = stb_q;
endmodule

// File: tb/tb_fp_mul_param.sv
// Directed-vector bench for fp_mul_param: single-precision instance plus a half-precision instance.
module tb_fp_mul_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a, b, z;
  logic        rm, stb, ack, zstb, zack;
  logic [3:0]  flags;
  logic [15:0] h_a, h_b, h_z;
  logic        h_rm, h_stb, h_ack, h_zstb, h_zack;
  logic [3:0]  h_flags;

  int n_chk = 0;
  int n_fail = 0;

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .input_a(a), .input_b(b), .round_mode(rm),
    .input_stb(stb), .input_ack(ack), .output_z(z), .output_flags(flags),
    .output_z_stb(zstb), .output_z_ack(zack)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .input_a(h_a), .input_b(h_b), .round_mode(h_rm),
    .input_stb(h_stb), .input_ack(h_ack), .output_z(h_z), .output_flags(h_flags),
    .output_z_stb(h_zstb), .output_z_ack(h_zack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic f_ack(input bit half);
    return half ? h_ack : ack;
  endfunction
  function automatic logic f_stb(input bit half);
    return half ? h_zstb : zstb;
  endfunction

  // Issues one operation, measures accept-to-valid latency, checks result, then consumes it.
  task automatic run_op(input bit half, input logic [31:0] va, input logic [31:0] vb,
                        input logic vrm, input logic [31:0] ez, input logic [3:0] ef,
                        input string tag);
    int n;
    n = 0;
    while (!f_ack(half) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    if (half) begin h_a = va[15:0]; h_b = vb[15:0]; h_rm = vrm; h_stb = 1'b1; end
    else      begin a = va; b = vb; rm = vrm; stb = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; h_stb = 1'b0;
    n = 1;
    while (!f_stb(half) && n < 20) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n - 1, 32'd5);
    check({tag, "_z"}, half ? {16'h0, h_z} : z, ez);
    check({tag, "_flags"}, {28'h0, half ? h_flags : flags}, {28'h0, ef});
    if (half) h_zack = 1'b1; else zack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    zack = 1'b0; h_zack = 1'b0;
    check({tag, "_idle"}, {30'h0, f_stb(half), f_ack(half)}, 32'h1);
  endtask

  initial begin
    int bad, n;
    a = '0; b = '0; rm = 1'b0; stb = 1'b0; zack = 1'b0;
    h_a = '0; h_b = '0; h_rm = 1'b0; h_stb = 1'b0; h_zack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {z, flags, zstb, ack}, 32'h0);
    rst = 1'b0;
    check("rst_ack_low", {31'h0, ack}, 32'h0);
    @(negedge clk);
    check("ack_after_rst", {31'h0, ack}, 32'h1);

    run_op(0, 32'h40800000, 32'h40A00000, 0, 32'h41A00000, 4'b0000, "mul_4x5");
    run_op(0, 32'hC0A00000, 32'h40000000, 0, 32'hC1200000, 4'b0000, "mul_m5x2");
    run_op(0, 32'h40E00000, 32'hC1100000, 0, 32'hC27C0000, 4'b0000, "mul_7xm9");
    run_op(0, 32'h3FC00000, 32'h3F800001, 0, 32'h3FC00002, 4'b0001, "rne");
    run_op(0, 32'h3FC00000, 32'h3F800001, 1, 32'h3FC00001, 4'b0001, "trunc");
    run_op(0, 32'h7F800000, 32'h00000000, 0, 32'h7FC00000, 4'b1000, "inf_x_zero");
    run_op(0, 32'hFF800000, 32'h40000000, 0, 32'hFF800000, 4'b0000, "ninf_x_2");
    run_op(0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b0000, "nan_in");
    run_op(0, 32'h7F000000, 32'h7F000000, 0, 32'h7F800000, 4'b0101, "ovf_rne");
    run_op(0, 32'h7F000000, 32'h7F000000, 1, 32'h7F7FFFFF, 4'b0101, "ovf_trunc");
    run_op(0, 32'h00800000, 32'h3F000000, 0, 32'h00000000, 4'b0011, "unf");
    run_op(0, 32'h00000001, 32'h40000000, 0, 32'h00000000, 4'b0000, "denorm");

    // Result held while the consumer stalls; new requests are not accepted.
    a = 32'h40800000; b = 32'h40A00000; rm = 1'b0; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h40000000; b = 32'h40000000;
    n = 1;
    while (!zstb && n < 20) begin @(negedge clk); n++; end
    check("stall_lat", n - 1, 32'd5);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(zstb === 1'b1 && z === 32'h41A00000 && flags === 4'h0 && ack === 1'b0)) bad++;
    end
    check("stall_hold", bad, 32'd0);
    stb = 1'b0;
    zack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    zack = 1'b0;
    check("stall_release", {zstb, ack}, 32'h1);
    check("stall_z_kept", z, 32'h41A00000);

    // Reset while the op sits in MULT.
    a = 32'h40E00000; b = 32'h40E00000; stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midop_rst", {z, flags, zstb, ack}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'h40800000, 32'h40A00000, 0, 32'h41A00000, 4'b0000, "after_rst");

    run_op(1, 32'h4400, 32'h4500, 0, 32'h4D00, 4'b0000, "half_4x5");
    run_op(1, 32'h7800, 32'h7800, 0, 32'h7C00, 4'b0101, "half_ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
